ycr1_cg_ctrl: RTL and testbench

Multi-channel automatic clock-gating controller for core sub-units such as the pipeline, debug, timer and bus bridges. Each channel tracks its unit's activity and gates that unit's clock after a programmable number of consecutive idle cycles. Each channel ungates on a request/acknowledge wake handshake. The block sits in the clock-control area next to the core reset logic and drives one gated clock per channel.

---
 rtl/ycr1_cg_pkg.sv | 15 +
 rtl/ycr1_cg_chan.sv | 114 +++++++++++
 rtl/ycr1_cg_ctrl.sv | 41 ++++
 tb/tb_ycr1_cg_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ycr1_cg_pkg.sv
// Shared types and constants for the multi-channel clock-gating controller.
package ycr1_cg_pkg;

  // Per-channel gating FSM states
  typedef enum logic [1:0] {
    ON    = 2'd0,
    COUNT = 2'd1,
    GATED = 2'd2,
    WAKE  = 2'd3
  } type_ycr1_cg_state_e;

  // Width of the per-channel wake-latency counter (covers WAKE_LAT up to 15)
  localparam int YCR1_CG_WAKE_CNT_W = 4;

endpackage

// File: rtl/ycr1_cg_chan.sv
// One clock-gating channel: idle tracking, gating FSM, wake handshake and a
// low-phase-transparent latch gate that keeps the gated clock glitch free.
module ycr1_cg_chan
  import ycr1_cg_pkg::*;
#(
  parameter int IDLE_W   = 8,
  parameter int WAKE_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              test_mode,
  input  logic [IDLE_W-1:0] cfg_idle_thr,
  input  logic              auto_en,
  input  logic              force_on,
  input  logic              busy,
  input  logic              wake_req,
  output logic              wake_ack,
  output logic              gated_sts,
  output logic              clk_out
);

  localparam logic [YCR1_CG_WAKE_CNT_W-1:0] WAKE_LAST = YCR1_CG_WAKE_CNT_W'(WAKE_LAT - 1);
  localparam logic [IDLE_W-1:0]             IDLE_MAX  = '1;
  localparam logic [IDLE_W-1:0]             IDLE_ONE  = IDLE_W'(1);

  type_ycr1_cg_state_e             state, state_next;
  logic [IDLE_W-1:0]               idle_cnt, idle_cnt_next;
  logic [YCR1_CG_WAKE_CNT_W-1:0]   wake_cnt, wake_cnt_next;
  logic                            ack_next;
  logic                            ack_done, ack_done_next;
  logic                            thr_zero;
  logic                            idle;
  logic                            req_new;
  logic                            fsm_en;
  logic                            latched_en;

  assign thr_zero  = (cfg_idle_thr == '0);
  assign idle      = auto_en & ~force_on & ~busy & ~wake_req & ~thr_zero;
  // A request only earns an ack once; it must go low before it can earn another
  assign req_new   = wake_req & ~ack_done;
  assign fsm_en    = (state != GATED);
  assign gated_sts = (state == GATED);
  assign ack_done_next = ack_next | (ack_done & wake_req);

  // Next-state, counter and ack decisions for the gating FSM
  always_comb begin
    state_next    = state;
    idle_cnt_next = idle_cnt;
    wake_cnt_next = wake_cnt;
    ack_next      = 1'b0;
    case (state)
      ON: begin
        idle_cnt_next = '0;
        if (req_new) ack_next = 1'b1;
        if (idle) begin
          state_next    = COUNT;
          idle_cnt_next = IDLE_ONE;
        end
      end
      COUNT: begin
        if (!idle) begin
          state_next    = ON;
          idle_cnt_next = '0;
        end else if (idle_cnt >= cfg_idle_thr) begin
          state_next    = GATED;
          idle_cnt_next = '0;
        end else if (idle_cnt != IDLE_MAX) begin
          idle_cnt_next = idle_cnt + IDLE_ONE;
        end
      end
      GATED: begin
        if (wake_req | busy | force_on | ~auto_en | thr_zero) begin
          state_next    = WAKE;
          wake_cnt_next = '0;
        end
      end
      WAKE: begin
        if (wake_cnt == WAKE_LAST) begin
          state_next    = ON;
          wake_cnt_next = '0;
          ack_next      = req_new;
        end else begin
          wake_cnt_next = wake_cnt + 1'b1;
        end
      end
      default: state_next = ON;
    endcase
  end

  // State, counters and the registered one-cycle ack pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ON;
      idle_cnt <= '0;
      wake_cnt <= '0;
      wake_ack <= 1'b0;
      ack_done <= 1'b0;
    end else begin
      state    <= state_next;
      idle_cnt <= idle_cnt_next;
      wake_cnt <= wake_cnt_next;
      wake_ack <= ack_next;
      ack_done <= ack_done_next;
    end
  end

  // Enable latch is transparent only while clk is low, so changes land on whole high phases
  always_latch begin
    if (!clk) latched_en = fsm_en | test_mode;
  end

  assign clk_out = latched_en & clk;

endmodule

// File: rtl/ycr1_cg_ctrl.sv
// Multi-channel automatic clock-gating controller: one independent channel per gated unit.
module ycr1_cg_ctrl
  import ycr1_cg_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int IDLE_W   = 8,
  parameter int WAKE_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              test_mode,
  input  logic [IDLE_W-1:0] cfg_idle_thr,
  input  logic [NUM_CH-1:0] cfg_auto_en,
  input  logic [NUM_CH-1:0] cfg_force_on,
  input  logic [NUM_CH-1:0] chan_busy,
  input  logic [NUM_CH-1:0] wake_req,
  output logic [NUM_CH-1:0] wake_ack,
  output logic [NUM_CH-1:0] clk_gated_sts,
  output logic [NUM_CH-1:0] clk_out
);

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_chan
    ycr1_cg_chan #(
      .IDLE_W   (IDLE_W),
      .WAKE_LAT (WAKE_LAT)
    ) u_chan (
      .clk          (clk),
      .rst_n        (rst_n),
      .test_mode    (test_mode),
      .cfg_idle_thr (cfg_idle_thr),
      .auto_en      (cfg_auto_en[ch]),
      .force_on     (cfg_force_on[ch]),
      .busy         (chan_busy[ch]),
      .wake_req     (wake_req[ch]),
      .wake_ack     (wake_ack[ch]),
      .gated_sts    (clk_gated_sts[ch]),
      .clk_out      (clk_out[ch])
    );
  end

endmodule

// File: tb/tb_ycr1_cg_ctrl.sv
// Self-checking bench for ycr1_cg_ctrl: directed scenarios with literal
// expectations, then randomized traffic against a behavioural channel model.
module tb_ycr1_cg_ctrl;

  localparam int NUM_CH   = 4;
  localparam int IDLE_W   = 8;
  localparam int WAKE_LAT = 2;
  localparam int RUN_MAX  = (1 << IDLE_W) - 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              test_mode = 1'b0;
  logic [IDLE_W-1:0] cfg_idle_thr = '0;
  logic [NUM_CH-1:0] cfg_auto_en = '0;
  logic [NUM_CH-1:0] cfg_force_on = '0;
  logic [NUM_CH-1:0] chan_busy = '0;
  logic [NUM_CH-1:0] wake_req = '0;
  logic [NUM_CH-1:0] wake_ack;
  logic [NUM_CH-1:0] clk_gated_sts;
  logic [NUM_CH-1:0] clk_out;

  int checks = 0;
  int passes = 0;
  logic cmp_en = 1'b0;

  // Behavioural model: gated flag, remaining wake cycles, length of the current idle run
  bit m_gated     [NUM_CH];
  int m_wake_left [NUM_CH];
  int m_run       [NUM_CH];
  bit m_ack       [NUM_CH];
  bit m_ack_done  [NUM_CH];
  bit m_en_prev   [NUM_CH];
  bit acked       [NUM_CH];

  ycr1_cg_ctrl #(
    .NUM_CH   (NUM_CH),
    .IDLE_W   (IDLE_W),
    .WAKE_LAT (WAKE_LAT)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .test_mode     (test_mode),
    .cfg_idle_thr  (cfg_idle_thr),
    .cfg_auto_en   (cfg_auto_en),
    .cfg_force_on  (cfg_force_on),
    .chan_busy     (chan_busy),
    .wake_req      (wake_req),
    .wake_ack      (wake_ack),
    .clk_gated_sts (clk_gated_sts),
    .clk_out       (clk_out)
  );

  // Free-running source clock, 10 time-unit period
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
  endtask

  // Advance the model by one rising edge for channel c using the inputs present at that edge
  task automatic modelStep(input int c);
    bit req, idle, elig, ack;
    req = wake_req[c];
    m_en_prev[c] = !rst_n || !m_gated[c];
    if (!rst_n) begin
      m_gated[c] = 0; m_wake_left[c] = 0; m_run[c] = 0; m_ack[c] = 0; m_ack_done[c] = 0;
      return;
    end
    idle = cfg_auto_en[c] && !cfg_force_on[c] && !chan_busy[c] && !req && (cfg_idle_thr != 0);
    elig = req && !m_ack_done[c];
    ack  = 0;
    if (m_wake_left[c] > 0) begin
      m_wake_left[c]--;
      if (m_wake_left[c] == 0) ack = elig;
    end else if (m_gated[c]) begin
      if (req || chan_busy[c] || cfg_force_on[c] || !cfg_auto_en[c] || cfg_idle_thr == 0) begin
        m_gated[c] = 0;
        m_wake_left[c] = WAKE_LAT;
      end
    end else begin
      if (req && m_run[c] == 0) ack = elig;
      if (!idle) m_run[c] = 0;
      else if (m_run[c] > 0 && m_run[c] >= int'(cfg_idle_thr)) begin
        m_gated[c] = 1;
        m_run[c] = 0;
      end else if (m_run[c] < RUN_MAX) m_run[c]++;
    end
    m_ack[c] = ack;
    m_ack_done[c] = ack || (m_ack_done[c] && req);
  endtask

  // Step the model on each rising edge, then compare every channel in the high phase
  always @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++) modelStep(c);
    #2;
    if (cmp_en) begin
      for (int c = 0; c < NUM_CH; c++) begin
        checkOutput($sformatf("wake_ack[%0d]", c), 32'(wake_ack[c]), 32'(m_ack[c]));
        checkOutput($sformatf("clk_gated_sts[%0d]", c), 32'(clk_gated_sts[c]), 32'(m_gated[c]));
        checkOutput($sformatf("clk_out_high[%0d]", c), 32'(clk_out[c]), 32'(m_en_prev[c] | test_mode));
      end
    end
  end

  // Gated clocks must be low whenever the source clock is low
  always @(negedge clk) begin
    #2;
    if (cmp_en) checkOutput("clk_out_low", 32'(clk_out), 32'(0));
  end

  // Every high pulse on a gated clock must last a full source high phase
  for (genvar g = 0; g < NUM_CH; g++) begin : g_pw
    time rise_t = 0;
    always @(posedge clk_out[g]) rise_t = $time;
    always @(negedge clk_out[g]) begin
      if (cmp_en) checkOutput($sformatf("pulse_width[%0d]", g), 32'(($time - rise_t) >= 5), 32'(1));
    end
  end

  task automatic waitHigh();
    @(posedge clk);
    #3;
  endtask

  // One cycle of randomized traffic obeying the wake handshake
  task automatic applyStimulus();
    @(negedge clk);
    if (!rst_n) rst_n = 1'b1;
    else if ($urandom_range(299) == 0) rst_n = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (wake_req[c]) begin
        if (wake_ack[c]) acked[c] = 1;
        if (acked[c] && $urandom_range(3) != 0) begin
          wake_req[c] = 1'b0;
          acked[c] = 0;
        end
      end else if ($urandom_range(19) == 0) begin
        wake_req[c] = 1'b1;
      end
      chan_busy[c] = ($urandom_range(7) == 0);
    end
    if ($urandom_range(49) == 0) cfg_idle_thr = IDLE_W'($urandom_range(5));
    if ($urandom_range(39) == 0) cfg_auto_en = NUM_CH'($urandom | $urandom);
    if ($urandom_range(39) == 0) cfg_force_on = NUM_CH'($urandom & $urandom & $urandom);
    if ($urandom_range(99) == 0) test_mode = ~test_mode;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    cmp_en = 1'b1;

    // Out of reset with auto-gating off: all clocks run, nothing gated or acked
    repeat (3) waitHigh();
    checkOutput("reset_sts", 32'(clk_gated_sts), 32'h0);
    checkOutput("reset_ack", 32'(wake_ack), 32'h0);
    checkOutput("reset_clk", 32'(clk_out), 32'hF);

    // Channel 0 gates on the edge after its 4th idle sample
    @(negedge clk);
    cfg_idle_thr = 8'd4;
    cfg_auto_en  = 4'b0001;
    repeat (4) waitHigh();
    checkOutput("gate_edge4", 32'(clk_gated_sts), 32'h0);
    waitHigh();
    checkOutput("gate_edge5", 32'(clk_gated_sts), 32'h1);
    waitHigh();
    checkOutput("gated_clk", 32'(clk_out), 32'hE);

    // Wake channel 0: clock back next period, ack WAKE_LAT cycles after leaving GATED
    @(negedge clk);
    wake_req[0] = 1'b1;
    waitHigh();
    checkOutput("wake_sts", 32'(clk_gated_sts), 32'h0);
    checkOutput("wake_ack_w0", 32'(wake_ack), 32'h0);
    waitHigh();
    checkOutput("wake_ack_w1", 32'(wake_ack), 32'h0);
    checkOutput("wake_clk", 32'(clk_out), 32'hF);
    waitHigh();
    checkOutput("wake_ack_w2", 32'(wake_ack), 32'h1);
    @(negedge clk);
    wake_req[0] = 1'b0;
    cfg_auto_en = 4'b0000;
    waitHigh();
    checkOutput("wake_ack_w3", 32'(wake_ack), 32'h0);

    // Busy on idle cycle 3 of 4 restarts the count on channel 1
    @(negedge clk);
    cfg_auto_en = 4'b0010;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chan_busy[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chan_busy[1] = 1'b0;
    repeat (4) waitHigh();
    checkOutput("busy_restart", 32'(clk_gated_sts), 32'h0);
    waitHigh();
    checkOutput("busy_regate", 32'(clk_gated_sts), 32'h2);

    // test_mode runs a gated clock; then reset in the middle of a wake
    @(negedge clk);
    cfg_auto_en = 4'b0110;
    repeat (6) waitHigh();
    checkOutput("ch2_gated", 32'(clk_gated_sts), 32'h6);
    @(negedge clk);
    test_mode = 1'b1;
    waitHigh();
    checkOutput("test_clk", 32'(clk_out), 32'hF);
    checkOutput("test_sts", 32'(clk_gated_sts), 32'h6);
    @(negedge clk);
    wake_req[2] = 1'b1;
    waitHigh();
    checkOutput("mid_wake_sts", 32'(clk_gated_sts), 32'h2);
    @(negedge clk);
    rst_n = 1'b0;
    wake_req[2] = 1'b0;
    test_mode = 1'b0;
    waitHigh();
    checkOutput("rst_sts", 32'(clk_gated_sts), 32'h0);
    checkOutput("rst_ack", 32'(wake_ack), 32'h0);
    checkOutput("rst_clk", 32'(clk_out), 32'hF);
    @(negedge clk);
    rst_n = 1'b1;
    waitHigh();
    checkOutput("rst_no_ack", 32'(wake_ack), 32'h0);

    // Randomized traffic against the model
    for (int i = 0; i < 2000; i++) applyStimulus();

    @(negedge clk);
    rst_n = 1'b1;
    wake_req = '0;
    repeat (4) @(posedge clk);
    #4;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
